// File: rtl/mux2_arbiter_if.sv
// Request/grant bundle between the two mux sources and the arbiter.
// master = requesting side, slave = arbiter side.
interface mux2_arbiter_if;
  logic [1:0] req;
  logic [1:0] grant;
  logic       sel;
  logic       busy;

  modport master (
    output req,
    input  grant,
    input  sel,
    input  busy
  );

  modport slave (
    input  req,
    output grant,
    output sel,
    output busy
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-source round-robin arbiter driving the 2:1 mux select.
// Define MUX2_ARB_PREEMPT_EN to compile in the HOLD_MAX hold-limit timer.
module mux2_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic CLK,
  input  logic n_Reset,
  mux2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX out of range 1..255");
  end

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       last_q, last_d;
  logic       entry;
  logic       hold_exp;
  logic [1:0] req;

  assign req = bus.req;

`ifdef MUX2_ARB_PREEMPT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] LIM  = CW'(HOLD_MAX);
  localparam logic [CW-1:0] LIM1 = CW'(HOLD_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign hold_exp = (cnt_q == LIM1);

  // Hold counter: cleared on entry, saturating while owned
  always_comb begin
    cnt_d = cnt_q;
    if (entry) begin
      cnt_d = '0;
    end else if (state_d != IDLE && cnt_q != LIM) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Hold counter register
  always_ff @(posedge CLK) begin
    if (!n_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign hold_exp = 1'b0;
`endif

  // Next state: release- and (optionally) hold-limit-driven handover
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OWN_A: begin
        if (req[1] && (!req[0] || hold_exp)) begin
          state_d = OWN_B;
        end else if (!req[0]) begin
          state_d = IDLE;
        end
      end
      OWN_B: begin
        if (req[0] && (!req[1] || hold_exp)) begin
          state_d = OWN_A;
        end else if (!req[1]) begin
          state_d = IDLE;
        end
      end
      default: begin
        unique case (1'b1)
          (req == 2'b01): state_d = OWN_A;
          (req == 2'b10): state_d = OWN_B;
          (req == 2'b11): state_d = last_q ? OWN_A : OWN_B;
          default:        state_d = IDLE;
        endcase
      end
    endcase
  end

  // Output and pointer next values derived from the next state
  always_comb begin
    entry   = (state_d != IDLE) && (state_d != state_q);
    grant_d = {state_d == OWN_B, state_d == OWN_A};
    busy_d  = (state_d != IDLE);
    sel_d   = sel_q;
    last_d  = last_q;
    if (state_d == OWN_A) sel_d = 1'b0;
    if (state_d == OWN_B) sel_d = 1'b1;
    if (entry) last_d = (state_d == OWN_B);
  end

  // FSM state and registered outputs
  always_ff @(posedge CLK) begin
    if (!n_Reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter.
// Covers both builds of MUX2_ARB_PREEMPT_EN.
module tb_mux2_arbiter;

  logic CLK = 1'b0;
  logic n_Reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  mux2_arbiter_if bus ();

  mux2_arbiter #(.HOLD_MAX(4)) dut (
    .CLK     (CLK),
    .n_Reset (n_Reset),
    .bus     (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] r);
    bus.req = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic outs(input string tag, input logic [1:0] g,
                      input logic s, input logic b);
    check({tag, ".grant"}, 8'(bus.grant), 8'(g));
    check({tag, ".sel"},   8'(bus.sel),   8'(s));
    check({tag, ".busy"},  8'(bus.busy),  8'(b));
  endtask

  initial begin
    n_Reset = 1'b0;
    bus.req = 2'b11;
    cyc(2'b11);
    cyc(2'b11);
    outs("rst", 2'b00, 1'b0, 1'b0);

    n_Reset = 1'b1;
    cyc(2'b11);
    outs("first", 2'b01, 1'b0, 1'b1);

    cyc(2'b10);
    outs("handover", 2'b10, 1'b1, 1'b1);
    cyc(2'b00);
    outs("release", 2'b00, 1'b1, 1'b0);

    cyc(2'b11);
    outs("rr_a", 2'b01, 1'b0, 1'b1);
    cyc(2'b00);
    outs("rr_idle", 2'b00, 1'b0, 1'b0);
    cyc(2'b11);
    outs("rr_b", 2'b10, 1'b1, 1'b1);
    cyc(2'b00);
    outs("idle2", 2'b00, 1'b1, 1'b0);

`ifdef MUX2_ARB_PREEMPT_EN
    for (int i = 0; i < 12; i++) begin
      cyc(2'b11);
      check($sformatf("pre%0d", i), 8'(bus.grant),
            ((i / 4) % 2) != 0 ? 8'h02 : 8'h01);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(2'b01);
      check($sformatf("keep%0d", i), 8'(bus.grant), 8'h01);
    end
    cyc(2'b11);
    check("sat_nopre", 8'(bus.grant), 8'h01);
    cyc(2'b00);
`else
    cyc(2'b01);
    check("own_a", 8'(bus.grant), 8'h01);
    for (int i = 0; i < 20; i++) begin
      cyc(2'b11);
      check($sformatf("nopre%0d", i), 8'(bus.grant), 8'h01);
    end
    cyc(2'b10);
    outs("nopre_hand", 2'b10, 1'b1, 1'b1);
    cyc(2'b11);
    check("b_holds", 8'(bus.grant), 8'h02);
    cyc(2'b00);
`endif
    outs("idle3", 2'b00, bus.sel, 1'b0);

    cyc(2'b01);
    cyc(2'b11);
    cyc(2'b01);
    cyc(2'b00);
    check("lost_req", 8'(bus.grant), 8'h00);

    cyc(2'b10);
    outs("own_b", 2'b10, 1'b1, 1'b1);
    n_Reset = 1'b0;
    cyc(2'b10);
    outs("rst_mid", 2'b00, 1'b0, 1'b0);
    n_Reset = 1'b1;
    cyc(2'b11);
    outs("post_rst", 2'b01, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-requester round-robin arbiter that drives the select input of the 2-to-1 multiplexer stage. Two sources (A on mux input 0, B on mux input 1) request the shared mux output, and the arbiter issues a one-hot grant plus a registered `sel`. `sel` wires directly to the mux select port. An optional hold-limit timer preempts a long-running owner when the other source is waiting.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive granted cycles before preemption. Legal range 1..255. Used only with `MUX2_ARB_PREEMPT_EN`.
- `CLK`  input  1  clock; all state updates on the rising edge.
- `n_Reset`  input  1  reset; one clock, synchronous, active-low.
- `req`  input  2  request; bit 0 = source A, bit 1 = source B; level-sensitive.
- `grant`  output  2  one-hot grant or 2'b00; bit 0 = A, bit 1 = B; registered.
- `sel`  output  1  mux select; 0 = A, 1 = B; registered.
- `busy`  output  1  high whenever `grant` != 2'b00.

## Operation
- States: IDLE, OWN_A, OWN_B.
- Priority pointer `last` records the most recently granted source. Reset value is B, so A wins the first tie.
- On the edge where `n_Reset` is sampled low: state IDLE, `grant`=00, `sel`=0, `busy`=0, `last`=B, hold counter 0. This overrides any grant in progress, including reset mid-ownership.
- IDLE transitions:
  - `req`=00: stay IDLE.
  - `req`=01: go to OWN_A.
  - `req`=10: go to OWN_B.
  - `req`=11: grant the source that is not `last`.
- OWN_X, owner still requesting: stay in OWN_X (subject to preemption).
- OWN_X, owner drops `req`:
  - If the other source is requesting, switch directly to OWN_other, with no idle cycle.
  - Otherwise go to IDLE.
- `last` updates on every entry to OWN_A or OWN_B.
- `sel` updates on the same edge as `grant`. In IDLE, `sel` holds its previous value so the mux output does not glitch.
- `grant` is never 2'b11. `busy` = `grant[0] | grant[1]`.
- Preemption (macro defined):
  - Hold counter, width `$clog2(HOLD_MAX+1)`, clears on every entry to OWN_X.
  - Increments each cycle in OWN_X and saturates at HOLD_MAX.
  - If counter == HOLD_MAX-1 and the other source is requesting: switch to OWN_other on the next edge, even though the owner still requests.
  - If the other source is not requesting, the owner keeps the grant indefinitely and the counter stays saturated.

## Timing
- Latency from request to grant: 1 cycle. `req` sampled at edge n gives `grant`/`sel` valid after edge n.
- A release seen at edge n gives the new grant, or IDLE, after edge n. There is no dead cycle on a handover.
- With preemption and contention, an owner holds the grant for exactly HOLD_MAX cycles.
- Simultaneous owner-drop and hold-limit expiry: both lead to OWN_other; a single transition, no double switch.
- `req` deasserted by a non-owner before it is granted: the request is lost, and nothing is latched.
- All outputs are registered. There are no combinational paths from `req` to outputs.

## Configuration
- `MUX2_ARB_PREEMPT_EN` defined:
  - Hold counter and HOLD_MAX preemption are compiled in, as described above.
- Not defined:
  - Counter logic is absent and `HOLD_MAX` is ignored.
  - The owner keeps the grant until it drops `req`; the arbiter is purely release-driven.
  - All other behaviour is identical.

## Test plan
- Reset and first request: hold `n_Reset`=0 for 2 cycles with `req`=11. Required: `grant`=00, `sel`=0, `busy`=0. Release reset with `req`=11. Required: `grant`=01, `sel`=0 one cycle later.
- Handover: A owns, `req` goes 11→10. Required: next cycle `grant`=10, `sel`=1, `busy` stays 1 throughout. Then `req`=00. Required: `grant`=00, `sel` stays 1.
- Round-robin tie: B last granted, IDLE, `req`=11. Required: `grant`=01. After release and `req`=11 again, required: `grant`=10.
- Preemption (macro on, HOLD_MAX=4): A owns with `req`=11 held. Required: `grant`=01 for exactly 4 cycles, then 10 for 4 cycles, alternating. With `req`=01 held, A keeps the grant indefinitely.
- No preemption (macro off): A owns, `req`=11 held for 20 cycles. Required: `grant`=01 throughout. `req`→10 gives `grant`=10 next cycle.
- Reset mid-ownership: B owns, `n_Reset`=0 for 1 cycle. Required: `grant`=00, `sel`=0, `busy`=0 after that edge. With `req`=11 after release, required: `grant`=01.
